// File: rtl/stage_wb.sv
`default_nettype none
// ============================================================================
// stage_wb : memory access + write-back pipeline register. Drives the
// data-memory request, stalls for a variable-latency ack, extends load data
// and registers the final register-file write.
// Optional feature macro: MISALIGN_TRAP_EN (suppress misaligned accesses).
// Revision: 1.0
// ============================================================================
module stage_wb #(
  parameter int RF_SRC_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_pc,
  input  logic [31:0]         mem_inst,
  input  logic [31:0]         mem_opResult,
  input  logic [31:0]         mem_memData,
  input  logic                mem_memWE,
  input  logic                mem_rfWE,
  input  logic [4:0]          mem_rfDst,
  input  logic [RF_SRC_W-1:0] mem_rfSrc,
  output logic                dm_req,
  output logic                dm_we,
  output logic [31:0]         dm_addr,
  output logic [3:0]          dm_be,
  output logic [31:0]         dm_wdata,
  input  logic [31:0]         dm_rdata,
  input  logic                dm_ack,
  output logic                stall,
  output logic [31:0]         wb_pc,
  output logic [31:0]         wb_inst,
  output logic                wb_rfWE,
  output logic [4:0]          wb_rfDst,
  output logic [31:0]         wb_rfData,
  output logic                wb_misalign
);

  localparam logic [5:0] c_OP_LB  = 6'h20;
  localparam logic [5:0] c_OP_LBU = 6'h24;
  localparam logic [5:0] c_OP_LH  = 6'h21;
  localparam logic [5:0] c_OP_LHU = 6'h25;
  localparam logic [5:0] c_OP_SB  = 6'h28;
  localparam logic [5:0] c_OP_SH  = 6'h29;

  localparam logic [RF_SRC_W-1:0] c_SRC_LOAD = RF_SRC_W'(1);
  localparam logic [RF_SRC_W-1:0] c_SRC_LINK = RF_SRC_W'(2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_wb_pc;
  logic [31:0] r_wb_inst;
  logic        r_wb_rfWE;
  logic [4:0]  r_wb_rfDst;
  logic [31:0] r_wb_rfData;
  logic        r_wb_misalign;

  logic [5:0]  w_op;
  logic [1:0]  w_off;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_signed;
  logic        w_access;
  logic        w_misalign;
  logic        w_req;
  logic        w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;
  logic [31:0] w_load;
  logic [31:0] w_rf_data;

  assign w_op      = mem_inst[31:26];
  assign w_off     = mem_opResult[1:0];
  assign w_is_byte = (w_op == c_OP_LB) || (w_op == c_OP_LBU) || (w_op == c_OP_SB);
  assign w_is_half = (w_op == c_OP_LH) || (w_op == c_OP_LHU) || (w_op == c_OP_SH);
  assign w_is_word = ~w_is_byte & ~w_is_half;
  assign w_signed  = (w_op == c_OP_LB) || (w_op == c_OP_LH);
  assign w_access  = mem_memWE | (mem_rfSrc == c_SRC_LOAD);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_access & ((w_is_half & w_off[0]) | (w_is_word & (w_off != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // WAIT keeps the request up regardless of decode; mem_* is frozen anyway.
  assign w_req   = (r_state == S_WAIT) | (w_access & ~w_misalign);
  assign w_stall = w_req & ~dm_ack;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_memData;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{mem_memData[7:0]}};
    end else if (w_is_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{mem_memData[15:0]}};
    end
  end

  always_comb begin
    w_lane8 = dm_rdata[7:0];
    case (w_off)
      2'd1:    w_lane8 = dm_rdata[15:8];
      2'd2:    w_lane8 = dm_rdata[23:16];
      2'd3:    w_lane8 = dm_rdata[31:24];
      default: w_lane8 = dm_rdata[7:0];
    endcase
    w_lane16 = w_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    w_load   = dm_rdata;
    if (w_is_byte) begin
      w_load = {{24{w_signed & w_lane8[7]}}, w_lane8};
    end else if (w_is_half) begin
      w_load = {{16{w_signed & w_lane16[15]}}, w_lane16};
    end
  end

  always_comb begin
    w_rf_data = mem_opResult;
    if (mem_rfSrc == c_SRC_LOAD) begin
      w_rf_data = w_load;
    end else if (mem_rfSrc == c_SRC_LINK) begin
      w_rf_data = mem_pc + 32'd8;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stall ? S_WAIT : S_IDLE;
    end
  end

  // Stalled cycles load a bubble so a waiting access never writes twice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_pc       <= 32'd0;
      r_wb_inst     <= 32'd0;
      r_wb_rfWE     <= 1'b0;
      r_wb_rfDst    <= 5'd0;
      r_wb_rfData   <= 32'd0;
      r_wb_misalign <= 1'b0;
    end else if (w_stall) begin
      r_wb_pc       <= 32'd0;
      r_wb_inst     <= 32'd0;
      r_wb_rfWE     <= 1'b0;
      r_wb_rfDst    <= 5'd0;
      r_wb_rfData   <= 32'd0;
      r_wb_misalign <= 1'b0;
    end else begin
      r_wb_pc       <= mem_pc;
      r_wb_inst     <= mem_inst;
      r_wb_rfWE     <= mem_rfWE & ~w_misalign;
      r_wb_rfDst    <= mem_rfDst;
      r_wb_rfData   <= w_rf_data;
      r_wb_misalign <= w_misalign;
    end
  end

  assign dm_req      = w_req;
  assign dm_we       = mem_memWE;
  assign dm_addr     = {mem_opResult[31:2], 2'b00};
  assign dm_be       = w_be;
  assign dm_wdata    = w_wdata;
  assign stall       = w_stall;
  assign wb_pc       = r_wb_pc;
  assign wb_inst     = r_wb_inst;
  assign wb_rfWE     = r_wb_rfWE;
  assign wb_rfDst    = r_wb_rfDst;
  assign wb_rfData   = r_wb_rfData;
  assign wb_misalign = r_wb_misalign;

endmodule
`default_nettype wire

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Memory-access plus write-back pipeline register. Sits directly downstream of the MEM stage register and consumes its mem_* outputs.
- Drives the data-memory request. Waits for a variable-latency acknowledge, stalling the pipeline meanwhile.
- Extracts and extends load data, then registers the final register-file write (wb_*) for the register file and forwarding.

Parameters:
- RF_SRC_W, 2, width of rfSrc select. Encoding: 0 = ALU result, 1 = memory load, 2 = link (pc+8), 3 = reserved, treated as 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_pc  in  32  pc of the instruction in MEM.
- mem_inst  in  32  instruction in MEM. Opcode [31:26] selects access size and sign.
- mem_opResult  in  32  ALU result; the byte address for loads and stores.
- mem_memData  in  32  store data, right-aligned.
- mem_memWE  in  1  store flag.
- mem_rfWE  in  1  register write enable.
- mem_rfDst  in  5  destination register.
- mem_rfSrc  in  RF_SRC_W  write-back source select.
- dm_req  out  1  data memory request.
- dm_we  out  1  write strobe.
- dm_addr  out  32  word address {mem_opResult[31:2],2'b00}.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  read data, valid with dm_ack.
- dm_ack  in  1  request completion.
- stall  out  1  freeze PC/IF/ID/EX/MEM registers.
- wb_pc  out  32  pc of the write-back instruction.
- wb_inst  out  32  instruction of the write-back instruction.
- wb_rfWE  out  1  register-file write enable.
- wb_rfDst  out  5  register-file destination.
- wb_rfData  out  32  register-file write data.
- wb_misalign  out  1  misaligned access flag (MISALIGN_TRAP_EN only; tied 0 otherwise).

Behaviour:
- Access decode:
  - access = mem_memWE | (mem_rfSrc==1). The all-zero MEM bubble performs no access.
  - Opcodes: 0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu, 0x23 lw, 0x28 sb, 0x29 sh, 0x2B sw. Any other opcode with access set is treated as word.
- Byte enables (little-endian):
  - Byte access: be = 1<<addr[1:0].
  - Halfword access: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word access: be = 4'b1111.
  - Loads also drive be.
- Store data: dm_wdata replicates the byte or halfword across all lanes. dm_we = mem_memWE.
- FSM states IDLE, WAIT.
  - IDLE: dm_req = access, combinational from mem_*.
    - access & dm_ack: completes this cycle, stall = 0.
    - access & !dm_ack: go to WAIT, stall = 1.
  - WAIT: dm_req = 1, stall = 1. mem_* is held stable by the stall. On dm_ack, complete, stall = 0, return to IDLE.
  - dm_ack while dm_req = 0 is ignored.
- Load extract:
  - Select the lane by addr[1:0] or addr[1].
  - Sign-extend for lb/lh; zero-extend for lbu/lhu; lw passes the word unchanged.
- wb_rfData mux:
  - rfSrc 0 or 3: mem_opResult.
  - rfSrc 1: extracted load data.
  - rfSrc 2: mem_pc + 8, modulo 2^32.
- WB register update on each rising edge:
  - Completing or non-access cycle: capture pc, inst, rfWE, rfDst, rfData.
  - Stalled cycle (stall = 1): load a bubble, i.e. all wb_* = 0, so nothing writes twice.
- Latency: one cycle from a non-stalled MEM to valid wb_*. An access adds N cycles for N cycles of dm_ack delay.
- Reset (rst = 0, asynchronous):
  - FSM goes to IDLE and all wb_* = 0 immediately.
  - dm_req, dm_we, stall follow from IDLE with the current mem_*. An in-flight WAIT is abandoned and any late dm_ack is ignored.
- Stores write no register when mem_rfWE = 0. A store with mem_rfWE = 1 still writes per rfSrc.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misalignment condition: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Effect: dm_req = 0, no stall, wb_rfWE = 0, wb_misalign = 1 for that instruction's WB cycle. wb_misalign is otherwise 0.
- Undefined: low address bits are ignored for enables beyond the access size (halfword uses addr[1], word uses none). wb_misalign is tied 0.

Test Plan:
- lw, addr 0x100, dm_ack same cycle, rdata 0xDEADBEEF, rfDst 5 -> stall never 1; next edge wb_rfWE=1, wb_rfDst=5, wb_rfData=0xDEADBEEF.
- lb, addr 0x103, ack after 2 cycles, rdata 0x80FF1234 -> stall=1 for 2 cycles with wb bubbles; then wb_rfData=0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh, addr 0x202, memData 0x0000ABCD -> dm_we=1, dm_be=4'b1100, dm_wdata=0xABCDABCD, wb_rfWE=0.
- Link rfSrc=2, mem_pc=0xFFFFFFFC -> wb_rfData=0x00000004 (wrap).
- Load in WAIT, rst pulsed low mid-wait, then ack arrives -> wb_* = 0, FSM IDLE, ack ignored, no register write.
- MISALIGN_TRAP_EN: lw addr 0x101 -> dm_req=0, stall=0, wb_misalign=1, wb_rfWE=0. Without the macro -> dm_addr=0x100, be=4'b1111.
